// File: rtl/mersenne_multiplier.sv
// Sequential shift-add multiplier feeding a Mersenne (2^P-1) reducer; one bit of b per cycle.
// Optional macro MERSENNE_LL_SUB2_EN adds an ADJ cycle that adds 2^P-3 (Lucas-Lehmer "-2" step).
module mersenne_multiplier #(
    parameter int P     = 13,
    parameter int WIDTH = 2 * P
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P-1:0]     a,
    input  logic [P-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             busy
);

    localparam int CNT_W = $clog2(P) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(P - 1);
`ifdef MERSENNE_LL_SUB2_EN
    localparam logic [WIDTH-1:0] LL_ADJ = (WIDTH'(1) << P) - WIDTH'(3);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [P-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0] acc_sum;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // operands are only taken in IDLE, and the product is held until out_ready is seen in DONE.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

    // The multiplicand is pre-shifted each cycle so no variable shifter is needed.
    assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    mcand_d  = WIDTH'(a);
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
`ifdef MERSENNE_LL_SUB2_EN
                    state_d = ADJ;
`else
                    product_d = acc_sum;
                    state_d   = DONE;
`endif
                end
            end
`ifdef MERSENNE_LL_SUB2_EN
            ADJ: begin
                acc_d     = acc_q + LL_ADJ;
                product_d = acc_q + LL_ADJ;
                state_d   = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

// File: doc/mersenne_multiplier.md
MERSENNE_MULTIPLIER -- requirements
Module: mersenne_multiplier

Interface
REQ-001 SHALL have parameter P, default 13: Mersenne exponent; operands are P bits.
REQ-002 SHALL have parameter WIDTH, default 2*P: product width, which matches the downstream reducer input.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand pair a/b is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port a, input, P bits: multiplicand.
REQ-008 SHALL have port b, input, P bits: multiplier; a==b gives squaring.
REQ-009 SHALL have port out_valid, output, 1 bit: product is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream reducer accepts the product.
REQ-011 SHALL have port product, output, WIDTH bits: result of a*b, or a*b+(2^P-3) per REQ-028.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, MUL, ADJ and DONE, with a 2-bit encoding.
REQ-014 SHALL drive in_ready = (state==IDLE) and not rst.
REQ-015 SHALL accept operands on a clock edge with in_valid&&in_ready: latch a and b, clear the accumulator and bit counter, and go to MUL.
REQ-016 SHALL ignore in_valid in states MUL, ADJ and DONE; operands are not queued.
REQ-017 SHALL process one bit of b per MUL cycle, LSB first: if b[i]=1, then acc += a<<i, and i increments.
REQ-018 SHALL use an accumulator WIDTH bits wide; no overflow is possible, since max (2^P-1)^2 < 2^WIDTH.
REQ-019 SHALL use no multiply, divide or modulo operators; shift-add only.
REQ-020 SHALL use a bit counter of width $clog2(P)+1 and leave MUL after exactly P MUL cycles, when i==P-1 is processed.
REQ-021 SHALL go from MUL to ADJ when the feature in REQ-028 is compiled in, otherwise directly to DONE.
REQ-022 SHALL assert out_valid only in DONE and hold product stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on a clock edge with out_valid&&out_ready, go to IDLE; out_valid falls on that edge and in_ready rises.
REQ-024 SHALL have latency, from the input handshake edge to the first cycle with out_valid=1, of P edges (macro off) or P+1 edges (macro on).
REQ-025 SHALL keep product and out_valid unchanged when out_ready is high outside DONE.
REQ-026 SHALL produce product=0 for zero operands (a=0 or b=0) with the same latency; there is no early exit.

Reset
REQ-027 SHALL, while rst is high at a clock edge, set state=IDLE, acc=0, product=0, out_valid=0 and the counter to 0; this aborts any in-flight operation, including one in DONE that is not yet consumed, and the operation is not resumed.

Configuration
REQ-028 SHALL compile in, when macro MERSENNE_LL_SUB2_EN is defined, the ADJ state (one cycle), in which acc += 2^P-3; the product then equals a*b - 2 mod (2^P-1) before reduction (Lucas-Lehmer step), and the maximum value (2^P-1)^2 + 2^P-3 < 2^WIDTH.
REQ-029 SHALL, when MERSENNE_LL_SUB2_EN is undefined, omit ADJ and set product = a*b exactly.

Verification
REQ-030 SHALL cover, with P=13 and macro off: a=3, b=5, out_ready=1 -> out_valid 13 edges after accept, product=15, in_ready=1 on the next cycle.
REQ-031 SHALL cover, with P=13 and macro off: a=b=8191 -> product=67092481 (0x3FFC001).
REQ-032 SHALL cover, with P=13 and macro on: a=b=4 -> product=8205, out_valid 14 edges after accept; reducing 8205 mod 8191 gives 14 = 4*4-2.
REQ-033 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and product is constant; out_ready=1 -> one handshake, then IDLE.
REQ-034 SHALL cover a new in_valid pulse while busy (a=7, b=9 during MUL of 3*5) -> ignored, product=15.
REQ-035 SHALL cover rst=1 for one cycle at MUL cycle 6 -> next cycle out_valid=0, product=0, in_ready=1; a new 2*2 then yields product 4.
